// File: rtl/bht_resolve_unit.sv
// bht_resolve_unit: in-order FIFO of outstanding BHT predictions; on resolve writes back the next 2-bit state and flags mispredict/flush
// Ports: pred_* push a {index, state} prediction (pred_ready when not full); res_valid/res_taken retire the oldest entry;
// wr_* registered BHT write port; mispredict/flush one-cycle pulses with wr_en; outstanding occupancy;
// branch_count/mispred_count saturating statistics; res_err sticky resolve-while-empty flag.
module bht_resolve_unit #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pred_valid,
  input  logic [ADDR_W-1:0]        pred_addr,
  input  logic [1:0]               pred_state,
  output logic                     pred_ready,
  input  logic                     res_valid,
  input  logic                     res_taken,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [1:0]               wr_data,
  output logic                     mispredict,
  output logic                     flush,
  output logic [$clog2(DEPTH):0]   outstanding,
  output logic [CNT_W-1:0]         branch_count,
  output logic [CNT_W-1:0]         mispred_count,
  output logic                     res_err
);
  localparam int PW = $clog2(DEPTH);
  logic [ADDR_W+1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_head, r_tail;
  logic [PW:0]       r_count;
  logic              r_ready, r_wr_en, r_mis, r_flush, r_err;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [1:0]        r_wr_data;
  logic [CNT_W-1:0]  r_bc, r_mc;
  logic [ADDR_W+1:0] w_head;
  logic [1:0]        w_state, w_next;
  logic              w_pop, w_mis, w_push;
  logic [PW:0]       w_count_nx;
  assign w_head  = r_mem[r_head];
  assign w_state = w_head[1:0];
  assign w_pop   = res_valid && (r_count != '0);
  assign w_mis   = w_pop && (w_state[1] != res_taken);
  // A pop frees a slot this edge, so a full FIFO still accepts a push alongside a correct pop.
  assign w_push  = pred_valid && (r_ready || w_pop) && !w_mis;
  assign w_next  = res_taken ? (w_state == 2'b00 ? 2'b01 : 2'b11)
                             : (w_state == 2'b11 ? 2'b10 : 2'b00);
  assign w_count_nx = w_mis ? '0 : r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
  always_ff @(posedge clk)
    if (w_push) r_mem[r_tail] <= {pred_addr, pred_state};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_ready   <= 1'b1;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= 2'b00;
      r_mis     <= 1'b0;
      r_flush   <= 1'b0;
      r_bc      <= '0;
      r_mc      <= '0;
      r_err     <= 1'b0;
    end else begin
      r_count   <= w_count_nx;
      r_ready   <= !w_count_nx[PW];
      r_head    <= w_mis ? '0 : r_head + PW'(w_pop);
      r_tail    <= w_mis ? '0 : r_tail + PW'(w_push);
      r_wr_en   <= w_pop;
      r_mis     <= w_mis;
      r_flush   <= w_mis;
      if (w_pop) begin
        r_wr_addr <= w_head[ADDR_W+1:2];
        r_wr_data <= w_next;
        r_bc      <= r_bc + CNT_W'(r_bc != '1);
      end
      if (w_mis) r_mc <= r_mc + CNT_W'(r_mc != '1);
      if (res_valid && r_count == '0) r_err <= 1'b1;
    end
  end
  assign pred_ready    = r_ready;
  assign outstanding   = r_count;
  assign wr_en         = r_wr_en;
  assign wr_addr       = r_wr_addr;
  assign wr_data       = r_wr_data;
  assign mispredict    = r_mis;
  assign flush         = r_flush;
  assign branch_count  = r_bc;
  assign mispred_count = r_mc;
  assign res_err       = r_err;
endmodule

// File: tb/tb_bht_resolve_unit.sv
// tb_bht_resolve_unit: scoreboard bench for bht_resolve_unit against a queue-based reference model
module tb_bht_resolve_unit;
  localparam int DEPTH = 4, AW = 10, CW = 4, CMAX = 15;
  logic clk = 0, rst = 1;
  logic pred_valid = 0, res_valid = 0, res_taken = 0;
  logic [AW-1:0] pred_addr = '0;
  logic [1:0] pred_state = '0;
  logic pred_ready, wr_en, mispredict, flush, res_err;
  logic [AW-1:0] wr_addr;
  logic [1:0] wr_data;
  logic [2:0] outstanding;
  logic [CW-1:0] branch_count, mispred_count;
  typedef struct {logic [AW-1:0] a; logic [1:0] s;} ent_t;
  typedef struct {logic [AW-1:0] a; logic [1:0] d; logic m;} exp_t;
  ent_t q[$];
  exp_t sb[$];
  exp_t m_e;
  int n_chk = 0, n_pass = 0, bc = 0, mc = 0;
  bit err = 0;
  logic [1:0] nx_t [4] = '{2'd1, 2'd3, 2'd3, 2'd3};
  logic [1:0] nx_n [4] = '{2'd0, 2'd0, 2'd0, 2'd2};

  bht_resolve_unit #(.DEPTH(DEPTH), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .pred_valid(pred_valid), .pred_addr(pred_addr),
    .pred_state(pred_state), .pred_ready(pred_ready), .res_valid(res_valid),
    .res_taken(res_taken), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .mispredict(mispredict), .flush(flush), .outstanding(outstanding),
    .branch_count(branch_count), .mispred_count(mispred_count), .res_err(res_err));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Monitor: every write-back pulse is matched against the oldest expected retirement.
  always @(negedge clk) if (!rst) begin
    if (wr_en) begin
      if (sb.size() == 0) chk("unexpected wr_en", 1, 0);
      else begin
        m_e = sb.pop_front();
        chk("wr_addr", wr_addr, m_e.a);
        chk("wr_data", wr_data, m_e.d);
        chk("mispredict", mispredict, m_e.m);
        chk("flush", flush, m_e.m);
      end
    end else chk("idle strobes", {mispredict, flush}, 0);
  end

  task automatic check_state();
    chk("outstanding", outstanding, q.size());
    chk("pred_ready", pred_ready, q.size() < DEPTH);
    chk("branch_count", branch_count, bc);
    chk("mispred_count", mispred_count, mc);
    chk("res_err", res_err, err);
  endtask

  task automatic check_reset();
    chk("rst pred_ready", pred_ready, 1);
    chk("rst outstanding", outstanding, 0);
    chk("rst wr_en", wr_en, 0);
    chk("rst wr_addr", wr_addr, 0);
    chk("rst wr_data", wr_data, 0);
    chk("rst mispredict", mispredict, 0);
    chk("rst flush", flush, 0);
    chk("rst branch_count", branch_count, 0);
    chk("rst mispred_count", mispred_count, 0);
    chk("rst res_err", res_err, 0);
  endtask

  task automatic clear_model();
    q.delete();
    sb.delete();
    bc = 0;
    mc = 0;
    err = 0;
  endtask

  task automatic do_reset();
    #5;
    rst = 1;
    pred_valid = 0;
    res_valid = 0;
    #1;
    check_reset();
    clear_model();
    @(posedge clk);
    #2;
    rst = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input bit pv, input logic [AW-1:0] pa, input logic [1:0] ps,
                       input bit rv, input bit rt);
    int sz;
    bit pop, mis;
    ent_t e;
    exp_t x;
    pred_valid = pv; pred_addr = pa; pred_state = ps; res_valid = rv; res_taken = rt;
    sz = q.size();
    pop = rv && sz > 0;
    mis = 0;
    if (rv && sz == 0) err = 1;
    if (pop) begin
      e = q.pop_front();
      mis = (e.s >= 2) != rt;
      x.a = e.a;
      x.d = rt ? nx_t[e.s] : nx_n[e.s];
      x.m = mis;
      sb.push_back(x);
      if (bc < CMAX) bc++;
      if (mis && mc < CMAX) mc++;
    end
    if (mis) q.delete();
    else if (pv && (sz < DEPTH || pop)) begin
      e.a = pa;
      e.s = ps;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    pred_valid = 0;
    res_valid = 0;
    check_state();
  endtask

  initial begin
    do_reset();
    cycle(1, 10'h0F0, 2'b00, 0, 0);
    cycle(0, 0, 0, 1, 1);
    for (int t = 0; t < 2; t++)
      for (int s = 0; s < 4; s++) begin
        cycle(1, AW'(16 * s + t), 2'(s), 0, 0);
        cycle(0, 0, 0, 1, t[0]);
      end
    for (int i = 0; i < 5; i++) cycle(1, AW'(10'h200 + i), 2'b11, 0, 0);
    cycle(1, 10'h3AA, 2'b11, 1, 1);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 1);
    cycle(1, 10'h101, 2'b11, 0, 0);
    cycle(1, 10'h102, 2'b01, 0, 0);
    cycle(1, 10'h103, 2'b10, 0, 0);
    cycle(1, 10'h155, 2'b00, 1, 0);
    cycle(0, 0, 0, 1, 1);
    cycle(1, 10'h002, 2'b10, 0, 0);
    cycle(0, 0, 0, 1, 1);
    for (int i = 0; i < 400; i++)
      cycle(bit'($urandom_range(0, 1)), AW'($urandom), 2'($urandom),
            $urandom_range(0, 2) == 0, bit'($urandom_range(0, 1)));
    while (q.size() > 0) cycle(0, 0, 0, 1, q[0].s[1]);
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1, AW'(10'h300 + i), 2'b11, 0, 0);
    cycle(0, 0, 0, 1, 1);
    pred_valid = 1;
    pred_addr = 10'h3FF;
    res_valid = 1;
    res_taken = 1;
    #7;
    rst = 1;
    #1;
    check_reset();
    clear_model();
    @(posedge clk);
    #1;
    check_reset();
    pred_valid = 0;
    res_valid = 0;
    #2;
    rst = 0;
    @(posedge clk);
    #1;
    check_state();
    @(posedge clk);
    #1;
    chk("scoreboard drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/bht_resolve_unit.md
# bht_resolve_unit

Resolve-side companion to the branch history table and 2-bit predictor. It records every prediction issued at fetch (table index plus 2-bit counter state) in an in-order FIFO. When each branch resolves, it retires the oldest entry, computes the next counter state, writes that state back to the table through a registered write port, and flags mispredictions so the front end can flush. It also keeps branch and misprediction statistics.

## Interface
Parameters:
- DEPTH, 4, number of outstanding predictions held; power of two, 2..16
- ADDR_W, 10, BHT index width (1024-entry table)
- CNT_W, 16, width of the statistics counters

Ports:
- clk  input  1  rising-edge clock for all state
- rst  input  1  asynchronous, active-high reset
- pred_valid  input  1  fetch issued a prediction this cycle
- pred_addr  input  ADDR_W  BHT index of the predicted branch
- pred_state  input  2  counter state read from the BHT for that branch
- pred_ready  output  1  FIFO can accept a push (count < DEPTH)
- res_valid  input  1  oldest outstanding branch resolved this cycle
- res_taken  input  1  actual outcome, 1 = taken
- wr_en  output  1  BHT write strobe, one-cycle pulse
- wr_addr  output  ADDR_W  BHT write index
- wr_data  output  2  updated counter state
- mispredict  output  1  one-cycle pulse, coincident with wr_en
- flush  output  1  one-cycle pulse, coincident with mispredict
- outstanding  output  $clog2(DEPTH)+1  current FIFO occupancy
- branch_count  output  CNT_W  number of branches resolved
- mispred_count  output  CNT_W  number of mispredictions
- res_err  output  1  sticky; set by res_valid while the FIFO is empty

## Operation
- Push: accepted when pred_valid && pred_ready; stores {pred_addr, pred_state} at the tail.
  - Push with pred_valid while full is dropped; no state change.
- Pop: when res_valid and the FIFO is non-empty, the head entry {a, s} is retired.
  - Predicted direction p = s[1]: 10 and 11 mean taken; 00 and 01 mean not taken.
  - mispredict = (p != res_taken).
- Next-state rule, which must match the predictor FSM exactly:
  - 00: taken goes to 01; not taken stays 00.
  - 01: taken goes to 11; not taken goes to 00.
  - 10: taken goes to 11; not taken goes to 00.
  - 11: taken stays 11; not taken goes to 10.
- Write-back: wr_addr = a, wr_data = next(s, res_taken), wr_en = 1 for exactly one cycle.
- Flush on mispredict: every entry younger than the retired one is discarded and occupancy goes to 0.
  - A push in the same cycle as a mispredicting pop is discarded; it is wrong-path.
- Simultaneous push and pop without mispredict: both take effect; occupancy unchanged, including when full.
- res_valid while empty: ignored (no write, no count change); res_err is set and stays set until rst.
- Statistics:
  - branch_count increments on every retired branch.
  - mispred_count increments on every misprediction.
  - Both saturate at all-ones; they do not wrap.
- Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH.

## Timing
- Reset values, applied asynchronously on rst high:
  - pred_ready = 1, outstanding = 0, wr_en = 0, wr_addr = 0, wr_data = 00.
  - mispredict = 0, flush = 0, branch_count = 0, mispred_count = 0, res_err = 0.
  - FIFO pointers = 0.
- Reset asserted mid-operation discards all outstanding entries, and any pending write is suppressed.
- pred_ready and outstanding are registered and reflect state after the last edge.
  - pred_ready is not combinationally dependent on res_valid.
- Latency: a pop accepted at edge N drives wr_en, wr_addr, wr_data, mispredict and flush high during cycle N to N+1, registered outputs.
  - All three strobes (wr_en, mispredict, flush) deassert at edge N+1 unless another pop occurs at N+1.
- Back-to-back pops are supported; one write per cycle.
- A write-back does not bypass into pred_state. Fetch-side staleness is tolerated.
- Counters update at the same edge as the pop.

## Test plan
- Reset, then push {addr=0x0F0, st=00} and resolve taken: wr_en pulse with wr_addr=0x0F0, wr_data=01, mispredict=1, flush=1, branch_count=1, mispred_count=1.
- Walk every state: push st=00,01,10,11 and resolve each not taken, then push the same four and resolve each taken.
  - Not-taken wr_data sequence: 00,00,00,10.
  - Taken wr_data sequence: 01,11,11,11.
  - mispredict pattern for the eight pops: 0,0,1,1,1,1,0,0.
- Fill to DEPTH=4 with st=11: pred_ready=0 and outstanding=4.
  - A fifth push is dropped.
  - Simultaneous push and correctly predicted pop keeps outstanding=4 with order preserved.
- Push 3 entries, st=11 for the oldest; resolve the oldest not taken: wr_data=10, flush=1, outstanding=0.
  - A push presented in the same cycle is not stored.
- res_valid with an empty FIFO: no wr_en, counts unchanged, res_err=1.
  - res_err stays 1 after later valid pops and clears only on rst.
- Assert rst asynchronously between clock edges with 2 entries outstanding and a pop in flight: all outputs return to reset values immediately, and no wr_en pulse follows.
